// File: rtl/sd74155_demux_buf.sv
// sd74155_demux_buf
// Buffered 1-to-4 demultiplexer. A single W-bit input word is delivered to
// one of four channel holding registers (A/B/C/D), each with its own
// valid/ack handshake. The target channel is picked explicitly by S
// (Mode=0) or by a round-robin pointer (Mode=1) that never skips a full
// channel: it stalls the input instead.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset
//   In       in   W-bit input word
//   InValid  in   In holds a word to deliver
//   InReady  out  target channel can take a word this cycle (combinational)
//   S        in   explicit channel select (0=A,1=B,2=C,3=D), Mode=0
//   Mode     in   0 = select by S, 1 = round-robin by Ptr
//   A..D     out  channel holding registers
//   V        out  per-channel valid, bit0=A .. bit3=D
//   Ack      in   per-channel consume strobe, same order as V
//   Ptr      out  round-robin pointer
//   Count    out  accepted-word counter, wraps modulo 256
module sd74155_demux_buf #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] In,
  input  logic         InValid,
  output logic         InReady,
  input  logic [1:0]   S,
  input  logic         Mode,
  output logic [W-1:0] A,
  output logic [W-1:0] B,
  output logic [W-1:0] C,
  output logic [W-1:0] D,
  output logic [3:0]   V,
  input  logic [3:0]   Ack,
  output logic [1:0]   Ptr,
  output logic [7:0]   Count
);

  logic [W-1:0] a_r, b_r, c_r, d_r;
  logic [3:0]   v_r;
  logic [1:0]   ptr_r;
  logic [7:0]   count_r;

  logic [1:0]   target_s;
  logic         in_ready_s;
  logic         accept_s;
  logic [3:0]   load_s;
  logic [3:0]   v_next_s;

  // Target selection, handshake and per-channel load/valid next-state.
  always_comb begin
    target_s   = 2'd0;
    in_ready_s = 1'b0;
    accept_s   = 1'b0;
    load_s     = 4'b0000;
    v_next_s   = 4'b0000;

    if (Mode) begin
      target_s = ptr_r;
    end else begin
      target_s = S;
    end

    // An ack on the target frees it in the same cycle, so a full channel
    // can be consumed and refilled on one edge.
    in_ready_s = !v_r[target_s] | Ack[target_s];
    accept_s   = InValid & in_ready_s;

    if (accept_s) begin
      load_s = 4'b0001 << target_s;
    end else begin
      load_s = 4'b0000;
    end

    // Acks on empty channels are harmless here; a load wins over an ack
    // on the same channel, so the old word counts as consumed.
    v_next_s = (v_r & ~Ack) | load_s;
  end

  // Channel registers, valid flags, pointer and counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r     <= '0;
      b_r     <= '0;
      c_r     <= '0;
      d_r     <= '0;
      v_r     <= 4'b0000;
      ptr_r   <= 2'd0;
      count_r <= 8'd0;
    end else begin
      if (load_s[0]) a_r <= In;
      if (load_s[1]) b_r <= In;
      if (load_s[2]) c_r <= In;
      if (load_s[3]) d_r <= In;
      v_r <= v_next_s;
      if (accept_s) begin
        count_r <= count_r + 8'd1;
        if (Mode) begin
          ptr_r <= ptr_r + 2'd1;
        end
      end
    end
  end

  assign InReady = in_ready_s;
  assign A       = a_r;
  assign B       = b_r;
  assign C       = c_r;
  assign D       = d_r;
  assign V       = v_r;
  assign Ptr     = ptr_r;
  assign Count   = count_r;

endmodule

// File: tb/tb_sd74155_demux_buf.sv
// Directed testbench for sd74155_demux_buf (W=2). Inputs change 1 time unit
// after each rising edge; outputs are checked at that point, well away from
// the next edge.
module tb_sd74155_demux_buf;

  logic       clk;
  logic       rst;
  logic [1:0] In;
  logic       InValid;
  logic       InReady;
  logic [1:0] S;
  logic       Mode;
  logic [1:0] A, B, C, D;
  logic [3:0] V;
  logic [3:0] Ack;
  logic [1:0] Ptr;
  logic [7:0] Count;

  int n_checks;
  int n_pass;

  sd74155_demux_buf #(.W(2)) dut (
    .clk(clk), .rst(rst), .In(In), .InValid(InValid), .InReady(InReady),
    .S(S), .Mode(Mode), .A(A), .B(B), .C(C), .D(D), .V(V), .Ack(Ack),
    .Ptr(Ptr), .Count(Count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it if the observed value is wrong.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " A"}, 32'(A), 32'd0);
    check({tag, " B"}, 32'(B), 32'd0);
    check({tag, " C"}, 32'(C), 32'd0);
    check({tag, " D"}, 32'(D), 32'd0);
    check({tag, " V"}, 32'(V), 32'd0);
    check({tag, " Ptr"}, 32'(Ptr), 32'd0);
    check({tag, " Count"}, 32'(Count), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;

    // Garbage, then a one-cycle reset with garbage still on the inputs.
    rst = 1'b0; In = 2'b11; InValid = 1'b1; S = 2'd2; Mode = 1'b1; Ack = 4'b0110;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; InValid = 1'b0; Ack = 4'b0000; Mode = 1'b0;
    check_all_zero("reset");
    #1;
    check("reset InReady", 32'(InReady), 32'd1);

    // Explicit select: 01 -> C, 10 -> A.
    InValid = 1'b1; In = 2'b01; S = 2'd2;
    tick();
    In = 2'b10; S = 2'd0;
    tick();
    InValid = 1'b0;
    check("sel C", 32'(C), 32'd1);
    check("sel A", 32'(A), 32'd2);
    check("sel V", 32'(V), 32'b0101);
    check("sel Count", 32'(Count), 32'd2);
    check("sel Ptr", 32'(Ptr), 32'd0);
    Ack = 4'b0101;
    tick();
    Ack = 4'b0000;
    check("ack clear V", 32'(V), 32'b0000);
    check("ack keeps A", 32'(A), 32'd2);

    // Round-robin fill of all four channels, then a stall.
    Mode = 1'b1; InValid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      In = 2'(i);
      tick();
    end
    check("rr A", 32'(A), 32'd0);
    check("rr B", 32'(B), 32'd1);
    check("rr C", 32'(C), 32'd2);
    check("rr D", 32'(D), 32'd3);
    check("rr V", 32'(V), 32'b1111);
    check("rr Ptr", 32'(Ptr), 32'd0);
    check("rr Count", 32'(Count), 32'd6);
    In = 2'b01;
    #1;
    check("rr stall InReady", 32'(InReady), 32'd0);
    tick();
    check("rr stall A", 32'(A), 32'd0);
    check("rr stall Count", 32'(Count), 32'd6);
    check("rr stall Ptr", 32'(Ptr), 32'd0);
    Ack = 4'b0001;
    #1;
    check("rr ack InReady", 32'(InReady), 32'd1);
    tick();
    Ack = 4'b0000; InValid = 1'b0;
    check("rr refill A", 32'(A), 32'd1);
    check("rr refill Ptr", 32'(Ptr), 32'd1);
    check("rr refill Count", 32'(Count), 32'd7);
    check("rr refill V", 32'(V), 32'b1111);

    // Same-cycle ack and refill of B, with a parallel ack on D.
    Mode = 1'b0; S = 2'd1; InValid = 1'b1; In = 2'b11; Ack = 4'b1010;
    #1;
    check("refill InReady", 32'(InReady), 32'd1);
    tick();
    InValid = 1'b0; Ack = 4'b0000;
    check("refill B", 32'(B), 32'd3);
    check("refill V", 32'(V), 32'b0111);
    check("refill Count", 32'(Count), 32'd8);
    check("refill Ptr hold", 32'(Ptr), 32'd1);
    Ack = 4'b1111;
    tick();
    check("drain V", 32'(V), 32'b0000);

    // Stray acks on empty channels change nothing.
    tick();
    Ack = 4'b0000;
    check("stray V", 32'(V), 32'b0000);
    check("stray Count", 32'(Count), 32'd8);
    check("stray A", 32'(A), 32'd1);
    check("stray B", 32'(B), 32'd3);

    // Wrap: from reset, 256 round-robin accepts with free-running acks.
    rst = 1'b1;
    tick();
    rst = 1'b0; Mode = 1'b1; InValid = 1'b1; Ack = 4'b1111;
    for (int i = 0; i < 256; i++) begin
      In = 2'(i);
      tick();
      if (i == 254) begin
        check("wrap Count 255", 32'(Count), 32'd255);
        check("wrap Ptr 3", 32'(Ptr), 32'd3);
      end
    end
    InValid = 1'b0; Ack = 4'b0000;
    check("wrap Count", 32'(Count), 32'd0);
    check("wrap Ptr", 32'(Ptr), 32'd0);
    check("wrap D", 32'(D), 32'd3);
    check("wrap V", 32'(V), 32'b1000);

    // Build V=1011, Count=7, then reset coincident with an accept.
    rst = 1'b1;
    tick();
    rst = 1'b0; Mode = 1'b0; InValid = 1'b1; In = 2'b01; S = 2'd2; Ack = 4'b0100;
    for (int i = 0; i < 4; i++) tick();
    S = 2'd0; In = 2'b10;
    tick();
    Ack = 4'b0000; S = 2'd1;
    tick();
    S = 2'd3;
    tick();
    InValid = 1'b0;
    check("mid V", 32'(V), 32'b1011);
    check("mid Count", 32'(Count), 32'd7);
    InValid = 1'b1; S = 2'd2; In = 2'b11; rst = 1'b1;
    tick();
    rst = 1'b0; InValid = 1'b0;
    check_all_zero("mid reset");
    #1;
    check("mid reset InReady", 32'(InReady), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sd74155_demux_buf.md
# sd74155_demux_buf

Buffered 1-to-4 demultiplexer, the distribution counterpart of the dual 4-input selector: accepts a W-bit word on a single input port and delivers it to one of four output channels A/B/C/D, each with a one-entry holding register and valid/ack handshake. Channel selection is either explicit through S or automatic round-robin. The block sits between a single word source and four independent consumers in the 7400-series datapath models.

## Interface
- W, default 2, data width of the input word and of each output channel.

- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- In  input  W  input data word.
- InValid  input  1  In holds a word to deliver.
- InReady  output  1  block accepts In this cycle; combinational.
- S  input  2  explicit channel select: 0=A, 1=B, 2=C, 3=D; used when Mode=0.
- Mode  input  1  0 = explicit select by S; 1 = round-robin by Ptr.
- A, B, C, D  output  W each  channel holding registers.
- V  output  4  per-channel valid; bit 0=A, 1=B, 2=C, 3=D.
- Ack  input  4  per-channel consume strobe, same bit order as V.
- Ptr  output  2  round-robin pointer.
- Count  output  8  total accepted words, wraps modulo 256.

## Operation
- Target channel T = Mode ? Ptr : S. Combinational, re-evaluated every cycle. A Mode or S change takes effect in the same cycle.
- InReady = !V[T] | Ack[T]. A full channel that is acked in the same cycle can be refilled in that cycle.
- Accept = InValid & InReady. On accept:
  - channel T register <= In and V[T] <= 1;
  - Count <= Count + 1;
  - if Mode=1, Ptr <= Ptr + 1 (mod 4, 3 wraps to 0).
- Ptr holds while Mode=0. It also holds on any cycle without an accept.
- Round-robin never skips a full channel. If V[Ptr]=1 and Ack[Ptr]=0, InReady=0 and the input stalls until that channel is acked.
- Ack[i] with V[i]=1 and no refill of channel i clears V[i]. The data register keeps its last value.
- Ack[i] with V[i]=0 is ignored.
- Simultaneous Ack[T] and accept into T: V[T] stays 1, the register loads the new word, and the old word counts as consumed.
- Acks to non-target channels are processed in parallel with an accept into T.
- Channels other than T are never written.
- InValid=0: no state change except ack clears.

## Timing
- Reset, synchronous on the clk edge with rst=1: A=B=C=D=0, V=0, Ptr=0, Count=0. rst overrides any accept or ack in the same cycle.
- Reset mid-operation: pending words are discarded with no delivery, and InReady reflects the post-reset state the next cycle (V=0, so InReady=1).
- Latency: a word accepted at edge n is visible on its channel with V set after edge n; 1 cycle.
- Throughput: 1 word/cycle sustained when each target channel is empty or acked in the accept cycle.
- InReady, T and Accept are purely combinational from V, Ack, Mode, S and Ptr. There is no combinational path from In to any output.
- Count and Ptr update on the same edge as the accept.

## Test plan
- Reset: drive garbage then rst=1 for 1 cycle -> A..D=0, V=0000, Ptr=0, Count=0, InReady=1.
- Explicit select, W=2, Mode=0: In=2'b01 S=2, then In=2'b10 S=0, InValid=1 for 2 cycles, no Ack -> C=01, A=10, V=0101, Count=2, Ptr=0.
- Round-robin: Mode=1, InValid=1 with In=0,1,2,3,1 on consecutive cycles, no Ack -> A=0, B=1, C=2, D=3 after 4 cycles, V=1111. Fifth word stalls with InReady=0 and Ptr=0. Pulse Ack[0] -> fifth word lands in A (A=1), Ptr=1, Count=5.
- Same-cycle ack+refill: V[1]=1, Mode=0, S=1, InValid=1, Ack[1]=1, In=2'b11 -> InReady=1, B=11 next cycle, V[1] stays 1.
- Stray ack and wrap: Ack=1111 with V=0000 -> no change. Accept 256 words with free-running acks -> Count returns to 0 and Ptr=0 (Mode=1).
- Reset mid-stream: V=1011, Count=7, rst=1 coincident with an accept -> after the edge all outputs are zero. The accepted word is not delivered.
